// File: rtl/sc_tx_buf_if.sv
// Byte-stream and UART-side handshake bundle for the transmit staging buffer.
// master = the buffer itself, slave = the cipher/UART environment around it.
interface sc_tx_buf_if #(
    parameter int ADDR_W = 5
);
    logic              in_data_rdy;
    logic [7:0]        in_data;
    logic              print_buf;
    logic              tx_busy;
    logic              tx_data_rdy;
    logic [7:0]        tx_data;
    logic [ADDR_W:0]   buf_count;
    logic              buf_empty;
    logic              buf_full;
    logic              overflow;
    logic              draining;

    modport master (
        input  in_data_rdy, in_data, print_buf, tx_busy,
        output tx_data_rdy, tx_data, buf_count,
        output buf_empty, buf_full, overflow, draining
    );

    modport slave (
        output in_data_rdy, in_data, print_buf, tx_busy,
        input  tx_data_rdy, tx_data, buf_count,
        input  buf_empty, buf_full, overflow, draining
    );
endinterface

// File: rtl/sc_tx_buf.sv
// FIFO staging buffer between the stream cipher and the UART transmitter.
// A print request drains the FIFO one byte per UART handshake, optionally adding CR/LF.
module sc_tx_buf #(
    parameter int ADDR_W      = 5,
    parameter bit APPEND_CRLF = 1'b1
) (
    input logic       clk,
    input logic       rst,
    sc_tx_buf_if.master bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, SEND, GUARD, WAIT, SEND_CR, SEND_LF
    } stateT;

    typedef enum logic [1:0] {
        SRC_DATA, SRC_CR, SRC_LF
    } srcT;

    stateT state, nextState;
    srcT   src;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic [ADDR_W:0]   count;
    logic [7:0]        txData;
    logic              txRdy;
    logic              ovf;

    logic empty, full;
    logic pop, loadCr, loadLf, drainDone;
    logic push, drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (bus.print_buf) begin
                    if (!empty)           nextState = SEND;
                    else if (APPEND_CRLF) nextState = SEND_CR;
                end
            end
            SEND, SEND_CR, SEND_LF: begin
                if (!bus.tx_busy) nextState = GUARD;
            end
            GUARD: nextState = WAIT;
            WAIT: begin
                if (!bus.tx_busy) begin
                    if (!empty)
                        nextState = SEND;
                    else if (src == SRC_DATA && APPEND_CRLF)
                        nextState = SEND_CR;
                    else if (src == SRC_CR)
                        nextState = SEND_LF;
                    else
                        nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        loadCr    = 1'b0;
        loadLf    = 1'b0;
        drainDone = 1'b0;
        if (!bus.tx_busy) begin
            pop       = (state == SEND);
            loadCr    = (state == SEND_CR);
            loadLf    = (state == SEND_LF);
            drainDone = (state == WAIT) && (nextState == IDLE);
        end
    end

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push = bus.in_data_rdy && (!full || pop);
    assign drop = bus.in_data_rdy && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            txData <= 8'h00;
            txRdy  <= 1'b0;
            ovf    <= 1'b0;
            src    <= SRC_LF;
        end else begin
            txRdy <= pop | loadCr | loadLf;
            if (push) wrPtr <= wrPtr + ADDR_W'(1);
            if (pop) begin
                rdPtr  <= rdPtr + ADDR_W'(1);
                txData <= mem[rdPtr];
                src    <= SRC_DATA;
            end else if (loadCr) begin
                txData <= 8'h0D;
                src    <= SRC_CR;
            end else if (loadLf) begin
                txData <= 8'h0A;
                src    <= SRC_LF;
            end
            unique case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            if (drop)           ovf <= 1'b1;
            else if (drainDone) ovf <= 1'b0;
        end
    end

    assign bus.tx_data_rdy = txRdy;
    assign bus.tx_data     = txData;
    assign bus.buf_count   = count;
    assign bus.buf_empty   = empty;
    assign bus.buf_full    = full;
    assign bus.overflow    = ovf;
    assign bus.draining    = (state != IDLE);
endmodule

// File: tb/tb_sc_tx_buf.sv
// Scoreboard bench for sc_tx_buf: queue-based reference model, UART busy model,
// directed scenarios followed by randomized fill/drain rounds.
module tb_sc_tx_buf;
    logic clk = 1'b0;
    logic rst;

    sc_tx_buf_if #(.ADDR_W(5)) b1 ();
    sc_tx_buf_if #(.ADDR_W(5)) b0 ();

    sc_tx_buf #(.ADDR_W(5), .APPEND_CRLF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.master)
    );
    sc_tx_buf #(.ADDR_W(5), .APPEND_CRLF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] expQ[$];
    logic [7:0] mq[$];
    bit movf = 1'b0;
    int pulseCyc[$];
    int fallCyc[$];
    int busyLen = 0;
    int busyCnt = 0;
    bit pendBusy = 1'b0;
    bit prevRdy = 1'b0;
    int b0Pulses = 0;
    int lastPrintCyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // Monitor + UART model: busy rises the cycle after a pulse for busyLen cycles.
    always @(negedge clk) begin
        if (b1.tx_data_rdy) begin
            pulseCyc.push_back(cyc);
            chk("pulse while busy", int'(b1.tx_busy), 0);
            chk("back-to-back pulse", int'(prevRdy), 0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected pulse: got 0x%02h expected none",
                         b1.tx_data);
            end else begin
                chk("tx byte", int'(b1.tx_data), int'(expQ.pop_front()));
            end
        end
        if (b0.tx_data_rdy) b0Pulses++;
        if (busyCnt > 0) busyCnt--;
        if (pendBusy) busyCnt = busyLen;
        pendBusy = b1.tx_data_rdy;
        if (b1.tx_busy === 1'b1 && busyCnt == 0) fallCyc.push_back(cyc);
        b1.tx_busy = (busyCnt > 0);
        prevRdy = b1.tx_data_rdy;
    end

    task automatic put(input logic [7:0] v);
        b1.in_data_rdy = 1'b1;
        b1.in_data = v;
        if (mq.size() < 32) mq.push_back(v);
        else movf = 1'b1;
        @(negedge clk);
        b1.in_data_rdy = 1'b0;
    endtask

    task automatic prn();
        lastPrintCyc = cyc;
        foreach (mq[i]) expQ.push_back(mq[i]);
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
        mq.delete();
        movf = 1'b0;
        b1.print_buf = 1'b1;
        @(negedge clk);
        b1.print_buf = 1'b0;
    endtask

    task automatic waitIdle(input int maxc);
        int k = 0;
        @(negedge clk);
        while ((b1.draining || expQ.size() != 0) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("drain timeout", int'(k >= maxc), 0);
        expQ.delete();
    endtask

    task automatic checkModel();
        chk("buf_count", int'(b1.buf_count), mq.size());
        chk("buf_full", int'(b1.buf_full), int'(mq.size() == 32));
        chk("buf_empty", int'(b1.buf_empty), int'(mq.size() == 0));
        chk("overflow", int'(b1.overflow), int'(movf));
    endtask

    initial begin
        int pre;
        int k;
        bit sawDrain;
        rst = 1'b1;
        b1.in_data_rdy = 1'b0; b1.in_data = 8'h00; b1.print_buf = 1'b0;
        b0.in_data_rdy = 1'b0; b0.in_data = 8'h00; b0.print_buf = 1'b0;
        b0.tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_data_rdy", int'(b1.tx_data_rdy), 0);
        chk("reset tx_data", int'(b1.tx_data), 0);
        chk("reset draining", int'(b1.draining), 0);
        checkModel();
        rst = 1'b0;
        @(negedge clk);

        // Basic drain with CR/LF, latency and spacing
        busyLen = 0;
        pulseCyc.delete();
        put(8'h41);
        put(8'h42);
        prn();
        waitIdle(200);
        chk("t1 pulses", pulseCyc.size(), 4);
        if (pulseCyc.size() > 0)
            chk("t1 latency", pulseCyc[0] - lastPrintCyc, 2);
        for (int i = 1; i < pulseCyc.size(); i++)
            chk("t1 spacing", pulseCyc[i] - pulseCyc[i-1], 3);
        chk("t1 draining", int'(b1.draining), 0);
        checkModel();

        // Overfill then drain
        for (int i = 0; i < 33; i++) put(8'(i));
        checkModel();
        prn();
        waitIdle(2000);
        checkModel();

        // Slow UART: pulse follows busy falling by two cycles
        busyLen = 10;
        pulseCyc.delete();
        fallCyc.delete();
        put(8'hA1); put(8'hA2); put(8'hA3);
        prn();
        waitIdle(2000);
        chk("t3 pulses", pulseCyc.size(), 5);
        for (int i = 0; i < 4; i++)
            if (i + 1 < pulseCyc.size() && i < fallCyc.size())
                chk("t3 busy-to-pulse", pulseCyc[i+1] - fallCyc[i], 2);

        // Inject a byte during GUARD; a second print is ignored
        busyLen = 0;
        put(8'h61);
        mq.delete();
        expQ.push_back(8'h61); expQ.push_back(8'h62);
        expQ.push_back(8'h0D); expQ.push_back(8'h0A);
        b1.print_buf = 1'b1;
        @(negedge clk);
        b1.print_buf = 1'b0;
        @(negedge clk);
        chk("t4 guard pulse", int'(b1.tx_data_rdy), 1);
        b1.in_data_rdy = 1'b1;
        b1.in_data = 8'h62;
        @(negedge clk);
        b1.in_data_rdy = 1'b0;
        b1.print_buf = 1'b1;
        chk("t4 draining", int'(b1.draining), 1);
        @(negedge clk);
        b1.print_buf = 1'b0;
        waitIdle(200);
        repeat (10) @(negedge clk);
        checkModel();

        // Empty print on both variants
        prn();
        waitIdle(200);
        b0Pulses = 0;
        sawDrain = 1'b0;
        b0.print_buf = 1'b1;
        @(negedge clk);
        b0.print_buf = 1'b0;
        repeat (6) begin
            sawDrain |= b0.draining;
            @(negedge clk);
        end
        chk("t5 nocrlf draining", int'(sawDrain), 0);
        chk("t5 nocrlf pulses", b0Pulses, 0);

        // Asynchronous reset during WAIT
        busyLen = 10;
        for (int i = 0; i < 6; i++) put(8'(8'h70 + i));
        expQ.push_back(mq[0]);
        mq.delete();
        pre = pulseCyc.size();
        b1.print_buf = 1'b1;
        @(negedge clk);
        b1.print_buf = 1'b0;
        k = 0;
        while (pulseCyc.size() == pre && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t6 first pulse", int'(k >= 50), 0);
        repeat (3) @(negedge clk);
        chk("t6 draining", int'(b1.draining), 1);
        chk("t6 count", int'(b1.buf_count), 5);
        #2 rst = 1'b1;
        #1;
        chk("t6 rst tx_data_rdy", int'(b1.tx_data_rdy), 0);
        chk("t6 rst tx_data", int'(b1.tx_data), 0);
        chk("t6 rst draining", int'(b1.draining), 0);
        chk("t6 rst count", int'(b1.buf_count), 0);
        chk("t6 rst empty", int'(b1.buf_empty), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        movf = 1'b0;
        expQ.delete();
        pre = pulseCyc.size();
        repeat (20) @(negedge clk);
        chk("t6 no pulse after reset", pulseCyc.size() - pre, 0);
        busyLen = 0;
        put(8'h55);
        prn();
        waitIdle(200);
        checkModel();

        // Randomized fill/drain rounds
        for (int it = 0; it < 20; it++) begin
            int n;
            busyLen = $urandom_range(0, 4);
            n = $urandom_range(0, 40);
            for (int j = 0; j < n; j++) put(8'($urandom));
            checkModel();
            prn();
            waitIdle(3000);
            checkModel();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_tx_buf.md
Name: sc_tx_buf

Overview:
Output staging buffer that sits directly downstream of the stream-cipher lab top (Lab4_140L) and feeds the UART transmitter. It accepts the cipher's one-byte-per-pulse output (L4_tx_data / L4_tx_data_rdy) into a FIFO. On a print command (L4_PrintBuf) it drains the FIFO to the UART transmitter, one byte per transmitter handshake, then optionally appends CR/LF. It decouples the cipher's burst output from the slow serial line.

Parameters:
ADDR_W, 5, log2 of FIFO depth (depth = 2**ADDR_W = 32 bytes)
APPEND_CRLF, 1, when 1 emit 8'h0D then 8'h0A after each drain; when 0 emit nothing extra

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_data_rdy  input  1  byte valid this cycle (from L4_tx_data_rdy)
in_data  input  8  byte to buffer (from L4_tx_data)
print_buf  input  1  drain request pulse (from L4_PrintBuf)
tx_busy  input  1  UART transmitter busy; rises the cycle after a tx_data_rdy pulse, falls when the byte is done
tx_data_rdy  output  1  one-cycle pulse: tx_data valid for the UART transmitter
tx_data  output  8  byte to transmit; registered, held until the next pulse
buf_count  output  ADDR_W+1  current FIFO occupancy, 0..2**ADDR_W
buf_empty  output  1  buf_count == 0
buf_full  output  1  buf_count == 2**ADDR_W
overflow  output  1  sticky: a write was dropped because the FIFO was full
draining  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO pointers and buf_count 0; tx_data_rdy 0; tx_data 8'h00; overflow 0. A reset mid-drain aborts immediately. Partially sent data is lost and no further pulses occur.
- FIFO: circular, write and read pointers ADDR_W bits wide, wrapping modulo depth.
  - Write when in_data_rdy=1 and (not full, or a pop occurs on the same edge).
  - Write when full with no simultaneous pop: byte dropped, overflow set to 1.
  - Simultaneous write and pop: buf_count unchanged.
  - Writes are accepted in every state, including while draining.
- State machine, registered, one transition per edge:
  - IDLE:
    - print_buf=1 and FIFO not empty -> SEND.
    - print_buf=1 and FIFO empty -> SEND_CR if APPEND_CRLF, else stay in IDLE.
    - Otherwise stay in IDLE.
  - SEND: if tx_busy=0, pop the FIFO head into tx_data, set tx_data_rdy=1, and go to GUARD. Else stay in SEND.
  - GUARD: tx_data_rdy returns to 0; unconditionally go to WAIT. This gives the UART one cycle to raise tx_busy.
  - WAIT: hold while tx_busy=1. When tx_busy=0, choose the next state in this order:
    - FIFO not empty -> SEND.
    - A data byte was last sent and APPEND_CRLF=1 -> SEND_CR.
    - CR was last sent -> SEND_LF.
    - Otherwise -> IDLE.
  - SEND_CR / SEND_LF: same as SEND, but load the constant 8'h0D / 8'h0A without popping the FIFO. Track which byte was last sent with a 2-bit source register: data, CR, or LF.
- Bytes written during a drain are sent in the same drain if they arrive before WAIT sees the FIFO empty. Otherwise they wait for the next print_buf.
- print_buf is ignored in any state other than IDLE. It does not queue.
- overflow clears when a drain completes (the WAIT -> IDLE transition). It is not cleared by print_buf alone.
- Latency: when print_buf is sampled on edge k with the FIFO non-empty and tx_busy low, the first tx_data_rdy is set on edge k+1 (in the SEND state) and is visible for the cycle after it.
- Spacing: with tx_busy held at 0, consecutive tx_data_rdy pulses are exactly 3 cycles apart.
- tx_data_rdy is never high for two consecutive cycles.
- buf_count, buf_empty, buf_full and draining are registered or derived from registers; no combinational path from any input.

Test Plan:
1. Write 0x41 and 0x42, pulse print_buf, tx_busy tied 0, APPEND_CRLF=1 -> tx_data_rdy pulses carry 0x41, 0x42, 0x0D, 0x0A in order, spaced 3 cycles apart; then buf_empty=1, draining=0, state IDLE.
2. Write 33 bytes 0x00..0x20 with no drain -> buf_full=1, buf_count=32, overflow=1. Pulse print_buf -> 32 bytes 0x00..0x1F out, then CR/LF, and overflow=0 afterwards.
3. UART model raises tx_busy for 10 cycles after each pulse; 3 bytes queued -> each pulse follows tx_busy falling by exactly 2 cycles (WAIT -> SEND, then registered output); no pulse occurs while tx_busy=1.
4. Queue 0x61 and print; inject 0x62 while the drain is in GUARD -> output is 0x61, 0x62, 0x0D, 0x0A. A second print_buf pulse during the drain has no effect.
5. print_buf with the FIFO empty: APPEND_CRLF=1 -> only 0x0D, 0x0A are sent; APPEND_CRLF=0 -> no pulse and draining stays 0.
6. Assert rst asynchronously (mid-cycle) during WAIT with 5 bytes queued -> all outputs reset immediately, buf_count=0, and no tx_data_rdy after release. A new write plus print_buf then works normally.
